// File: rtl/rbcp_pkg.sv
// Shared types and helpers for the RBCP local-bus register responder.
package rbcp_pkg;

  localparam int unsigned RBCP_AW = 32;
  localparam int unsigned RBCP_DW = 8;
  // Index width covers up to 128 control plus 128 status bytes.
  localparam int unsigned RBCP_IW = 8;

  typedef enum logic [1:0] {RBCP_IDLE, RBCP_WAIT, RBCP_ACK} rbcp_state_t;

  // Window offset; addresses below the base wrap to large values and miss.
  function automatic logic [RBCP_AW-1:0] rbcp_offset(input logic [RBCP_AW-1:0] addr,
                                                      input logic [RBCP_AW-1:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/rbcp_addr_decode.sv
// Combinational classification of an RBCP address into control byte, status byte or miss.
module rbcp_addr_decode
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned        NUM_CTRL  = 16,
  parameter int unsigned        NUM_STAT  = 8
) (
  input  logic [RBCP_AW-1:0] addr,
  output logic               hit_c,
  output logic               ctrl_c,
  output logic               stat_c,
  output logic [RBCP_IW-1:0] ctrl_idx_c,
  output logic [RBCP_IW-1:0] stat_idx_c
);

  logic [RBCP_AW-1:0] off;
  logic [RBCP_AW-1:0] stat_off;

  always_comb begin
    off        = rbcp_offset(addr, BASE_ADDR);
    stat_off   = off - RBCP_AW'(NUM_CTRL);
    ctrl_c     = (off < RBCP_AW'(NUM_CTRL));
    stat_c     = !ctrl_c && (off < RBCP_AW'(NUM_CTRL + NUM_STAT));
    hit_c      = ctrl_c || stat_c;
    ctrl_idx_c = RBCP_IW'(off);
    stat_idx_c = RBCP_IW'(stat_off);
  end

endmodule

// File: rtl/rbcp_reg_responder.sv
// RBCP local-bus responder: byte-wide control/status register file with fixed-latency LOC_ACK.
// Optional RBCP_PULSE_REG_EN makes the highest control byte write-one-to-pulse.
module rbcp_reg_responder
  import rbcp_pkg::*;
#(
  parameter logic [RBCP_AW-1:0]    BASE_ADDR = 32'h0000_0000,
  parameter int unsigned           NUM_CTRL  = 16,
  parameter int unsigned           NUM_STAT  = 8,
  parameter int unsigned           ACK_LAT   = 1,
  parameter logic [8*NUM_CTRL-1:0] CTRL_INIT = '0
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    LOC_ACT,
  input  logic [RBCP_AW-1:0]      LOC_ADDR,
  input  logic [RBCP_DW-1:0]      LOC_WD,
  input  logic                    LOC_WE,
  input  logic                    LOC_RE,
  output logic                    LOC_ACK,
  output logic [RBCP_DW-1:0]      LOC_RD,
  output logic [8*NUM_CTRL-1:0]   CTRL_REG,
  output logic [NUM_CTRL-1:0]     CTRL_WR_STB,
  input  logic [8*NUM_STAT-1:0]   STAT_IN
);

  localparam int unsigned CW    = 8 * NUM_CTRL;
  localparam int unsigned CNT_W = 4;
`ifdef RBCP_PULSE_REG_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif
  localparam logic [CW-1:0]      PULSE_MASK = PULSE_EN ? (CW'(8'hFF) << (8 * (NUM_CTRL - 1))) : '0;
  localparam logic [CW-1:0]      CTRL_RST   = CTRL_INIT & ~PULSE_MASK;
  localparam logic [RBCP_IW-1:0] PULSE_IDX  = RBCP_IW'(NUM_CTRL - 1);

  rbcp_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic               ctrl_q;
  logic [RBCP_IW-1:0] idx_q;
  logic [RBCP_DW-1:0] stat_q;

  logic               hit_c;
  logic               ctrl_c;
  logic               stat_c;
  logic [RBCP_IW-1:0] ctrl_idx_c;
  logic [RBCP_IW-1:0] stat_idx_c;
  logic               accept_c;
  logic [RBCP_DW-1:0] stat_live_c;
  logic               sel_we_c;
  logic               sel_ctrl_c;
  logic [RBCP_IW-1:0] sel_idx_c;
  logic [RBCP_DW-1:0] sel_stat_c;
  logic [RBCP_DW-1:0] ctrl_byte_c;
  logic [RBCP_DW-1:0] rd_c;

  rbcp_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_CTRL  (NUM_CTRL),
    .NUM_STAT  (NUM_STAT)
  ) u_decode (
    .addr       (LOC_ADDR),
    .hit_c      (hit_c),
    .ctrl_c     (ctrl_c),
    .stat_c     (stat_c),
    .ctrl_idx_c (ctrl_idx_c),
    .stat_idx_c (stat_idx_c)
  );

  // Strobe qualification; a miss is simply never accepted.
  assign accept_c = (state == RBCP_IDLE) && LOC_ACT && (LOC_WE || LOC_RE) && hit_c;

  // Status byte as seen on the strobe cycle.
  always_comb begin
    stat_live_c = '0;
    for (int i = 0; i < NUM_STAT; i++) begin
      if (stat_c && (stat_idx_c == RBCP_IW'(i))) stat_live_c = STAT_IN[8*i +: 8];
    end
  end

  // Read source: live decode when leaving IDLE directly, latched access otherwise.
  always_comb begin
    sel_we_c    = (state == RBCP_IDLE) ? LOC_WE : we_q;
    sel_ctrl_c  = (state == RBCP_IDLE) ? ctrl_c : ctrl_q;
    sel_idx_c   = (state == RBCP_IDLE) ? ctrl_idx_c : idx_q;
    sel_stat_c  = (state == RBCP_IDLE) ? stat_live_c : stat_q;
    ctrl_byte_c = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (sel_idx_c == RBCP_IW'(i)) ctrl_byte_c = CTRL_REG[8*i +: 8];
    end
    if (PULSE_EN && (sel_idx_c == PULSE_IDX)) ctrl_byte_c = '0;
    if (sel_we_c)        rd_c = '0;
    else if (sel_ctrl_c) rd_c = ctrl_byte_c;
    else                 rd_c = sel_stat_c;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= RBCP_IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      ctrl_q      <= 1'b0;
      idx_q       <= '0;
      stat_q      <= '0;
      LOC_ACK     <= 1'b0;
      LOC_RD      <= '0;
      CTRL_REG    <= CTRL_RST;
      CTRL_WR_STB <= '0;
    end else begin
      LOC_ACK     <= 1'b0;
      LOC_RD      <= '0;
      CTRL_WR_STB <= '0;
      // Pulse byte self-clears unless rewritten below.
      CTRL_REG    <= CTRL_REG & ~PULSE_MASK;
      case (state)
        RBCP_IDLE: begin
          if (accept_c) begin
            we_q   <= LOC_WE;
            ctrl_q <= ctrl_c;
            idx_q  <= ctrl_c ? ctrl_idx_c : stat_idx_c;
            stat_q <= stat_live_c;
            if (LOC_WE && ctrl_c) begin
              for (int i = 0; i < NUM_CTRL; i++) begin
                if (ctrl_idx_c == RBCP_IW'(i)) begin
                  CTRL_REG[8*i +: 8] <= LOC_WD;
                  CTRL_WR_STB[i]     <= 1'b1;
                end
              end
            end
            if (ACK_LAT == 1) begin
              state   <= RBCP_ACK;
              LOC_ACK <= 1'b1;
              LOC_RD  <= rd_c;
            end else begin
              state <= RBCP_WAIT;
              cnt   <= CNT_W'(ACK_LAT - 1);
            end
          end
        end
        RBCP_WAIT: begin
          if (!LOC_ACT) begin
            state <= RBCP_IDLE;
          end else if (cnt == CNT_W'(1)) begin
            state   <= RBCP_ACK;
            LOC_ACK <= 1'b1;
            LOC_RD  <= rd_c;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RBCP_ACK: state <= RBCP_IDLE;
        default:  state <= RBCP_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Scoreboard bench for rbcp_reg_responder: one ACK_LAT=1 instance and one ACK_LAT=4 instance.
module tb_rbcp_reg_responder;

  typedef struct packed {
    logic [31:0] cyc;
    logic        chk_rd;
    logic [7:0]  rd;
  } exp_t;

`ifdef RBCP_PULSE_REG_EN
  localparam logic [7:0] P_AFTER = 8'h00;
  localparam logic [7:0] P_READ  = 8'h00;
`else
  localparam logic [7:0] P_AFTER = 8'h03;
  localparam logic [7:0] P_READ  = 8'h03;
`endif

  logic         clk = 1'b0;
  logic         rst_n [2];
  logic         act   [2];
  logic [31:0]  addr  [2];
  logic [7:0]   wd    [2];
  logic         we    [2];
  logic         re    [2];
  logic         ack   [2];
  logic [7:0]   rd    [2];
  logic [127:0] ctrl  [2];
  logic [15:0]  stb   [2];
  logic [63:0]  stat  [2];
  logic [127:0] m     [2];

  logic [31:0] cyc = '0;
  bit          mon_en = 1'b0;
  int          total = 0;
  int          passed = 0;
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  rbcp_reg_responder #(
    .BASE_ADDR (32'h0000_0100), .NUM_CTRL (16), .NUM_STAT (8), .ACK_LAT (1),
    .CTRL_INIT ('0)
  ) dut0 (
    .CLK (clk), .RSTn (rst_n[0]), .LOC_ACT (act[0]), .LOC_ADDR (addr[0]),
    .LOC_WD (wd[0]), .LOC_WE (we[0]), .LOC_RE (re[0]), .LOC_ACK (ack[0]),
    .LOC_RD (rd[0]), .CTRL_REG (ctrl[0]), .CTRL_WR_STB (stb[0]), .STAT_IN (stat[0])
  );

  rbcp_reg_responder #(
    .BASE_ADDR (32'h0000_0100), .NUM_CTRL (16), .NUM_STAT (8), .ACK_LAT (4),
    .CTRL_INIT (128'h80)
  ) dut1 (
    .CLK (clk), .RSTn (rst_n[1]), .LOC_ACT (act[1]), .LOC_ADDR (addr[1]),
    .LOC_WD (wd[1]), .LOC_WE (we[1]), .LOC_RE (re[1]), .LOC_ACK (ack[1]),
    .LOC_RD (rd[1]), .CTRL_REG (ctrl[1]), .CTRL_WR_STB (stb[1]), .STAT_IN (stat[1])
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    else passed++;
  endtask

  // Monitor: every ACK pops the scoreboard; otherwise LOC_RD must idle at zero.
  task automatic mon_one(input int d, input logic a, input logic [7:0] r);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
    e = '0;
    if (have) e = (d == 0) ? q0[0] : q1[0];
    if (a === 1'b1) begin
      chk($sformatf("ack_expected_dut%0d", d), {127'b0, a}, {127'b0, have});
      if (have) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("ack_cycle_dut%0d", d), {96'b0, cyc}, {96'b0, e.cyc});
        if (e.chk_rd) chk($sformatf("ack_rd_dut%0d", d), {120'b0, r}, {120'b0, e.rd});
      end
    end else begin
      chk($sformatf("rd_idle_dut%0d", d), {120'b0, r}, 128'h0);
      if (have && (cyc >= e.cyc)) begin
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        chk($sformatf("ack_present_dut%0d", d), {127'b0, a}, 128'h1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, ack[0], rd[0]);
      mon_one(1, ack[1], rd[1]);
    end
  end

  // Drive a one-cycle strobe; returns in cycle T+1 with strobes low and LOC_ACT still high.
  task automatic strobe(input int d, input logic [31:0] a, input logic w, input logic r,
                        input logic [7:0] data, input bit hit, input bit chk_rd,
                        input logic [7:0] erd);
    exp_t e;
    @(posedge clk); #1;
    act[d] = 1'b1; addr[d] = a; we[d] = w; re[d] = r; wd[d] = data;
    if (hit) begin
      e.cyc    = cyc + ((d == 0) ? 32'd1 : 32'd4);
      e.chk_rd = chk_rd;
      e.rd     = erd;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk); #1;
    we[d] = 1'b0; re[d] = 1'b0;
  endtask

  task automatic finish_access(input int d);
    repeat ((d == 0) ? 1 : 4) @(posedge clk);
    #1 act[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; act[d] = 1'b0; addr[d] = '0; wd[d] = '0;
      we[d] = 1'b0; re[d] = 1'b0; stat[d] = '0;
    end
    m[0] = '0;
    m[1] = 128'h80;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack0", {127'b0, ack[0]}, 128'h0);
    chk("reset_rd0", {120'b0, rd[0]}, 128'h0);
    chk("reset_ctrl0", ctrl[0], m[0]);
    chk("reset_stb0", {112'b0, stb[0]}, 128'h0);
    chk("reset_ctrl1", ctrl[1], m[1]);
    chk("reset_ack1", {127'b0, ack[1]}, 128'h0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    mon_en = 1'b1;

    // Control write and readback, ACK_LAT=1.
    strobe(0, 32'h103, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00);
    m[0][24 +: 8] = 8'h5A;
    chk("wr_ctrl_t1", ctrl[0], m[0]);
    chk("wr_stb_t1", {112'b0, stb[0]}, 128'h0008);
    @(posedge clk); #1;
    chk("wr_stb_t2", {112'b0, stb[0]}, 128'h0);
    act[0] = 1'b0;
    strobe(0, 32'h103, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A);
    finish_access(0);

    // Status read samples on the strobe cycle; status write is acked but inert.
    stat[0] = 64'h0000_0000_00C3_0000;
    strobe(0, 32'h112, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3);
    stat[0] = '0;
    finish_access(0);
    strobe(0, 32'h112, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'h00);
    chk("stat_wr_ctrl", ctrl[0], m[0]);
    chk("stat_wr_stb", {112'b0, stb[0]}, 128'h0);
    finish_access(0);

    // Misses: below base, just past status, and wrap-around top address.
    strobe(0, 32'h0FF, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00);
    chk("miss_lo_stb", {112'b0, stb[0]}, 128'h0);
    finish_access(0);
    strobe(0, 32'h118, 1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00);
    finish_access(0);
    strobe(0, 32'hFFFF_FFFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    finish_access(0);
    repeat (20) @(posedge clk);
    #1 chk("miss_ctrl", ctrl[0], m[0]);
    // Still IDLE: an immediate hit is acked on schedule.
    strobe(0, 32'h103, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A);
    finish_access(0);

    // WE and RE together behave as a write.
    strobe(0, 32'h101, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    m[0][8 +: 8] = 8'h77;
    chk("we_re_ctrl", ctrl[0], m[0]);
    chk("we_re_stb", {112'b0, stb[0]}, 128'h0002);
    finish_access(0);
    strobe(0, 32'h101, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h77);
    finish_access(0);

    // Highest control byte: plain R/W or one-cycle pulse depending on build.
    strobe(0, 32'h10F, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 8'h00);
    m[0][120 +: 8] = 8'h03;
    chk("top_byte_t1", ctrl[0], m[0]);
    chk("top_stb_t1", {112'b0, stb[0]}, 128'h8000);
    @(posedge clk); #1;
    m[0][120 +: 8] = P_AFTER;
    chk("top_byte_t2", ctrl[0], m[0]);
    act[0] = 1'b0;
    strobe(0, 32'h10F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, P_READ);
    finish_access(0);

    // ACK_LAT=4: write, then read with a second RE ignored during WAIT.
    strobe(1, 32'h103, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 8'h00);
    m[1][24 +: 8] = 8'h3C;
    chk("lat4_wr_ctrl", ctrl[1], m[1]);
    chk("lat4_wr_stb", {112'b0, stb[1]}, 128'h0008);
    finish_access(1);
    strobe(1, 32'h103, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
    @(posedge clk); #1 re[1] = 1'b1;
    @(posedge clk); #1 re[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1 act[1] = 1'b0;
    repeat (6) @(posedge clk);

    // Status sampled at T, held until the ACK at T+4.
    stat[1] = 64'h0000_0000_00C3_0000;
    strobe(1, 32'h112, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3);
    stat[1] = '0;
    finish_access(1);

    // LOC_ACT dropped at T+2: no ACK, committed write kept.
    strobe(1, 32'h100, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 act[1] = 1'b0;
    repeat (8) @(posedge clk);
    strobe(1, 32'h102, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00);
    @(posedge clk); #1 act[1] = 1'b0;
    m[1][16 +: 8] = 8'h55;
    repeat (8) @(posedge clk);
    #1 chk("abort_wr_kept", ctrl[1], m[1]);

    // Reset during WAIT restores CTRL_INIT and suppresses the ACK.
    strobe(1, 32'h100, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00);
    chk("rst_pre_byte0", {120'b0, ctrl[1][7:0]}, 128'h11);
    @(posedge clk); #1 rst_n[1] = 1'b0;
    @(posedge clk); #1 rst_n[1] = 1'b1;
    m[1] = 128'h80;
    chk("rst_ctrl1", ctrl[1], m[1]);
    chk("rst_stb1", {112'b0, stb[1]}, 128'h0);
    act[1] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_ctrl1_hold", ctrl[1], m[1]);
    chk("queues_drained", 128'(q0.size() + q1.size()), 128'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
